shift_rot_engine: RTL and testbench
===================================

# shift_rot_engine

Parametrised multi-cycle shift/rotate engine. It is the successor to the fixed 6-bit single-step shift register. It accepts a WIDTH-bit word plus a shift amount over a valid/ready handshake, then applies one single-position shift per clock for `amount` cycles. Modes are logical shift, rotate and arithmetic shift, in either direction. It returns the result and the last bit shifted out over a second valid/ready handshake. It sits between a command source and a consumer in the datapath test environments.

## Interface
Clock is `clk`. Reset is `reset`: synchronous and active-high.

Parameters:
- WIDTH, 8: data word width, must be ≥ 2.
- AMT_W, $clog2(WIDTH+1): width of `amount`, so `amount = WIDTH` is representable.

Ports:
- clk  in  1  clock, all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  engine can accept a command (high only in IDLE).
- datain  in  WIDTH  operand word.
- amount  in  AMT_W  number of single-position steps.
- mode  in  2  00 logical shift, 01 rotate, 10 arithmetic shift, 11 treated as 00.
- direction  in  1  1 = left (toward MSB), 0 = right.
- serial_in  in  1  fill bit for logical shifts, sampled on every step edge.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- dataout  out  WIDTH  result word.
- last_out  out  1  bit expelled by the final step; 0 if amount = 0.
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, capture datain into work, amount into cnt, and latch mode and direction.
  - Go to SHIFT if amount ≠ 0, otherwise DONE with work = datain.
- SHIFT, on each edge:
  - Apply one step to work and set last_out to the expelled bit.
  - cnt ← cnt − 1.
  - When cnt = 1 on that edge, go to DONE.
- DONE:
  - out_valid = 1; dataout = work.
  - On an edge with out_ready = 1, go to IDLE.
- Step rules for one position:
  - Logical left: {w[W-2:0], serial_in}. Logical right: {serial_in, w[W-1:1]}.
  - Rotate left: {w[W-2:0], w[W-1]}. Rotate right: {w[0], w[W-1:1]}.
  - Arithmetic right: {w[W-1], w[W-1:1]}. Arithmetic left: {w[W-2:0], 1'b0}.
  - Expelled bit is w[W-1] for left steps and w[0] for right steps.
- amount > WIDTH is legal and steps literally:
  - Rotate wraps naturally.
  - Logical shift yields the fill history.
  - Arithmetic right saturates to all sign bits.
- datain, amount, mode and direction are ignored outside IDLE. serial_in is ignored outside SHIFT.
- dataout and last_out hold their values outside DONE. They change only on capture or a step.

## Timing
- Reset: state goes to IDLE; work, dataout, cnt and last_out go to 0; out_valid = 0 and busy = 0. in_ready = 0 while reset is high.
- Reset mid-SHIFT or mid-DONE aborts the operation with no output. in_ready = 1 on the first cycle after reset is released.
- Latency: with acceptance at edge E0, out_valid rises after edge E0 + amount (amount = 0 gives one edge).
- Throughput: one command per amount + 2 cycles at best. in_ready is never high in DONE, so there is no capture on the result-handoff edge.
- Handshakes: a transfer occurs on an edge where valid and ready are both high. out_valid stays high and dataout stays stable until out_ready is seen.
- in_valid and out_ready may be held high permanently. The engine then cycles IDLE → SHIFT → DONE → IDLE.

## Structure
- Package shift_rot_pkg holds:
  - typedef enum logic [1:0] shift_mode_e {SM_LSL_LSR = 2'b00, SM_ROT = 2'b01, SM_ARITH = 2'b10}.
  - typedef enum logic [1:0] state_e {IDLE, SHIFT, DONE}.
- Sub-module shift_rot_step is the purely combinational one-position step. Parameters: WIDTH. Inputs: w, mode, direction, serial_in. Outputs: w_next, expelled.
- shift_rot_engine instantiates shift_rot_step once and holds the FSM, counter and registers.

## Test plan (WIDTH = 8)
- Rotate left, datain 8'hB4, amount 3 → dataout 8'hA5, last_out 1, out_valid rises 3 edges after acceptance.
- Logical right, datain 8'h81, amount 2, serial_in 1 → dataout 8'hE0, last_out 0.
- Arithmetic right, datain 8'h90, amount 3 → dataout 8'hF2, last_out 0. Also amount 9 → 8'hFF.
- Amount 0, datain 8'h3C → dataout 8'h3C, last_out 0, out_valid one edge after acceptance.
- Hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 and new datain → dataout stable, in_ready 0, no new capture; result released on the first out_ready edge.
- Assert reset for one edge mid-SHIFT → next cycle all outputs 0 except in_ready 1; a fresh command then completes correctly.

Source files
------------

// File: rtl/shift_rot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_rot_pkg
// Description : Shared mode and FSM state encodings for the shift/rotate
//               engine and its one-position step datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_rot_pkg;

    // Operation selector; encoding 2'b11 is treated as a logical shift.
    typedef enum logic [1:0] {
        SM_LSL_LSR = 2'b00,
        SM_ROT     = 2'b01,
        SM_ARITH   = 2'b10
    } shift_mode_e;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage : shift_rot_pkg
`default_nettype wire

// File: rtl/shift_rot_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_rot_step
// Description : Purely combinational single-position shift/rotate step.
//               Produces the next work word and the bit pushed off the end.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rot_step
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             serial_in,
    output logic [WIDTH-1:0] w_next,
    output logic             expelled
);

    // One-position step; left moves toward the MSB, right toward the LSB.
    always_comb begin
        w_next   = w;
        expelled = direction ? w[WIDTH-1] : w[0];
        case (shift_mode_e'(mode))
            SM_ROT: begin
                w_next = direction ? {w[WIDTH-2:0], w[WIDTH-1]}
                                   : {w[0], w[WIDTH-1:1]};
            end
            SM_ARITH: begin
                // Arithmetic left is a plain zero-fill shift; right keeps the sign.
                w_next = direction ? {w[WIDTH-2:0], 1'b0}
                                   : {w[WIDTH-1], w[WIDTH-1:1]};
            end
            default: begin
                // Logical shift (also the reserved 2'b11 encoding): fill from serial_in.
                w_next = direction ? {w[WIDTH-2:0], serial_in}
                                   : {serial_in, w[WIDTH-1:1]};
            end
        endcase
    end

endmodule : shift_rot_step
`default_nettype wire

// File: rtl/shift_rot_engine.sv
`default_nettype none
// ============================================================================
// Module      : shift_rot_engine
// Description : Multi-cycle shift/rotate engine. Accepts a word and a step
//               count over valid/ready, applies one single-position step per
//               clock, and returns the result plus the last expelled bit over
//               a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rot_engine
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             serial_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic             last_out,
    output logic             busy
);

    localparam logic [AMT_W-1:0] C_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] C_ZERO = '0;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic             r_last;
    logic [1:0]       r_mode;
    logic             r_dir;
    logic             w_accept;
    logic [WIDTH-1:0] w_step;
    logic             w_expelled;

    shift_rot_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .w         (r_work),
        .mode      (r_mode),
        .direction (r_dir),
        .serial_in (serial_in),
        .w_next    (w_step),
        .expelled  (w_expelled)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is suppressed while in reset.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (amount != C_ZERO) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == C_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Work word, step counter and command latches: load on capture, step in SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
            r_mode <= 2'b00;
            r_dir  <= 1'b0;
        end else if (w_accept) begin
            r_work <= datain;
            r_cnt  <= amount;
            r_last <= 1'b0;
            r_mode <= mode;
            r_dir  <= direction;
        end else if (r_state == SHIFT) begin
            r_work <= w_step;
            r_last <= w_expelled;
            r_cnt  <= r_cnt - C_ONE;
        end
    end

    assign dataout  = r_work;
    assign last_out = r_last;

endmodule : shift_rot_engine
`default_nettype wire

// File: tb/tb_shift_rot_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rot_engine
// Description : Directed self-checking bench for shift_rot_engine (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rot_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] datain;
    logic [AMT_W-1:0] amount;
    logic [1:0]       mode;
    logic             direction;
    logic             serial_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataout;
    logic             last_out;
    logic             busy;

    int n_tests;
    int n_fail;

    shift_rot_engine #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .amount    (amount),
        .mode      (mode),
        .direction (direction),
        .serial_in (serial_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .last_out  (last_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one command, wait for the result, hand it off. Reports the result,
    // the number of edges after acceptance before out_valid, and busy in DONE.
    task automatic do_cmd(input logic [7:0] d, input logic [3:0] amt, input logic [1:0] md,
                          input logic dir, input logic ser,
                          output logic [7:0] res, output logic lst, output int lat,
                          output logic bsy, output logic to);
        int k;
        to = 1'b0;
        lat = 0;
        res = '0;
        lst = 1'b0;
        bsy = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; datain = d; amount = amt; mode = md; direction = dir; serial_in = ser;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        res = dataout;
        lst = last_out;
        bsy = busy;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            dataout !== 8'h00 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b dataout=%h last=%b, want 0 0 0 00 0",
                     in_ready, out_valid, busy, dataout, last_out);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    // Generic directed vector: check result, last bit, latency and busy.
    task automatic test_vector(input string name, input logic [7:0] d, input logic [3:0] amt,
                               input logic [1:0] md, input logic dir, input logic ser,
                               input logic [7:0] exp_d, input logic exp_l);
        logic [7:0] r; logic l; int lat; logic b; logic to;
        do_cmd(d, amt, md, dir, ser, r, l, lat, b, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for handshake", name);
        end else if (r !== exp_d || l !== exp_l || lat != int'(amt) || b !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got data=%h last=%b lat=%0d busy=%b want data=%h last=%b lat=%0d busy=1",
                     name, r, l, lat, b, exp_d, exp_l, amt);
        end
    endtask

    task automatic test_rotate();
        test_vector("rot_left_b4_3",  8'hB4, 4'd3,  2'b01, 1'b1, 1'b0, 8'hA5, 1'b1);
        test_vector("rot_right_01_1", 8'h01, 4'd1,  2'b01, 1'b0, 1'b0, 8'h80, 1'b1);
        test_vector("rot_left_81_10", 8'h81, 4'd10, 2'b01, 1'b1, 1'b0, 8'h06, 1'b0);
    endtask

    task automatic test_logical();
        test_vector("lsr_81_2_s1",    8'h81, 4'd2, 2'b00, 1'b0, 1'b1, 8'hE0, 1'b0);
        test_vector("lsl_5a_4_s1",    8'h5A, 4'd4, 2'b00, 1'b1, 1'b1, 8'hAF, 1'b1);
        test_vector("mode11_f0_5_s0", 8'hF0, 4'd5, 2'b11, 1'b0, 1'b0, 8'h07, 1'b1);
    endtask

    task automatic test_arith();
        test_vector("asr_90_3", 8'h90, 4'd3, 2'b10, 1'b0, 1'b0, 8'hF2, 1'b0);
        test_vector("asr_90_9", 8'h90, 4'd9, 2'b10, 1'b0, 1'b0, 8'hFF, 1'b1);
        test_vector("asl_c1_2", 8'hC1, 4'd2, 2'b10, 1'b1, 1'b1, 8'h04, 1'b1);
    endtask

    task automatic test_amount_zero();
        test_vector("amt0_3c", 8'h3C, 4'd0, 2'b01, 1'b1, 1'b1, 8'h3C, 1'b0);
    endtask

    // Result held in DONE under back-pressure while a new command is pending.
    task automatic test_backpressure();
        int k;
        @(negedge clk);
        in_valid = 1'b1; datain = 8'hB4; amount = 4'd3; mode = 2'b01; direction = 1'b1;
        @(posedge clk);
        #1 datain = 8'h55; amount = 4'd1;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_reach_done: timeout");
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (dataout !== 8'hA5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: dataout=%h in_ready=%b out_valid=%b want A5 0 1",
                         i, dataout, in_ready, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dataout !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b dataout=%h want 0 1 A5",
                     out_valid, in_ready, dataout);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 8'hAA || last_out !== 1'b0 || k != 1) begin
            n_fail++;
            $display("FAIL bp_next_cmd: out_valid=%b dataout=%h last=%b lat=%0d want 1 AA 0 1",
                     out_valid, dataout, last_out, k);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Reset for one edge in the middle of a long shift, then a fresh command.
    task automatic test_reset_mid_shift();
        @(negedge clk);
        in_valid = 1'b1; datain = 8'hB4; amount = 4'd6; mode = 2'b01; direction = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            dataout !== 8'h00 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: in_ready=%b out_valid=%b busy=%b dataout=%h last=%b want 1 0 0 00 0",
                     in_ready, out_valid, busy, dataout, last_out);
        end
        test_vector("after_reset_rot", 8'hB4, 4'd3, 2'b01, 1'b1, 1'b0, 8'hA5, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1; in_valid = 1'b0; datain = '0; amount = '0; mode = 2'b00;
        direction = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
        test_reset();
        test_rotate();
        test_logical();
        test_arith();
        test_amount_zero();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_rot_engine
`default_nettype wire
